// File: rtl/mult_pkg.sv
// Shared types and sizing for the NAF term sequencer in front of the
// two-term shift-add multiplier.
package mult_pkg;

  localparam int A_N = 16;
  localparam int N   = 4;
  localparam int B_W = 1 << N;

  // Signed product width: multiplicand + multiplier + one guard bit.
  function automatic int calc_p_w(input int a_n, input int n);
    return a_n + (1 << n) + 1;
  endfunction

  localparam int P_W = calc_p_w(A_N, N);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_ISSUE,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  typedef logic signed [1:0] naf_digit_t;

  localparam naf_digit_t DIGIT_ZERO = 2'sb00;
  localparam naf_digit_t DIGIT_POS  = 2'sb01;
  localparam naf_digit_t DIGIT_NEG  = 2'sb11;

  typedef struct packed {
    logic [N-1:0] i;
    logic [N-1:0] j;
    logic         one_term;
    logic         b_sign;
    logic         neg;
  } mult_term_t;

endpackage

// File: rtl/naf_encoder.sv
// Combinational non-adjacent-form recoder for a signed B_W-bit multiplier.
// Digit k is +1 / -1 / 0; every signed B_W-bit value fits in B_W digits.
module naf_encoder
  import mult_pkg::*;
(
  input  logic [B_W-1:0]         i_b,
  output naf_digit_t [B_W-1:0]   o_digits
);

  localparam logic [B_W+1:0] ONE = {{(B_W+1){1'b0}}, 1'b1};

  logic [B_W+1:0] w_x;

  // Peel digits LSB first: odd residue picks +1 (x mod 4 == 1) or -1
  // (x mod 4 == 3); halving after removing -1 is floor(x/2) + 1.
  always_comb begin
    w_x      = {{2{i_b[B_W-1]}}, i_b};
    o_digits = '0;
    for (int k = 0; k < B_W; k++) begin
      if (w_x[0]) begin
        o_digits[k] = w_x[1] ? DIGIT_NEG : DIGIT_POS;
        w_x = w_x[1] ? ({w_x[B_W+1], w_x[B_W+1:1]} + ONE)
                     : {w_x[B_W+1], w_x[B_W+1:1]};
      end else begin
        w_x = {w_x[B_W+1], w_x[B_W+1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_term_sequencer.sv
// Operand front end and signed accumulator for the two-term multiplier.
// Optional build macro: MULT_SEQ_ZERO_BYPASS_EN (skip requests when a == 0).
//
//   state  | meaning
//   IDLE   | waiting for an operand, in_rdy high
//   ENCODE | NAF digits loaded, first term pair selected
//   ISSUE  | request on m_*, waiting for m_result_vld
//   GAP    | one idle cycle, next pair selected
//   DONE   | product held on out_p until out_rdy
module mult_term_sequencer
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [A_N-1:0]        in_a,
  input  logic [B_W-1:0]        in_b,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic signed [P_W-1:0] out_p,
  output logic [A_N-1:0]        m_a,
  output logic [N-1:0]          m_b_i,
  output logic [N-1:0]          m_b_j,
  output logic                  m_one_term,
  output logic                  m_b_sign,
  output logic                  m_vld,
  input  logic [2*A_N-1:0]      m_c,
  input  logic                  m_result_vld
);

  seq_state_e                r_state;
  logic [A_N-1:0]            r_a;
  logic [B_W-1:0]            r_b;
  naf_digit_t [B_W-1:0]      r_digits;
  mult_term_t                r_term;
  logic signed [P_W-1:0]     r_acc;
  logic                      r_in_rdy;
  logic                      r_out_vld;
  logic                      r_m_vld;

  naf_digit_t [B_W-1:0]      w_enc_digits;
  naf_digit_t [B_W-1:0]      w_rem_digits;
  mult_term_t                w_first_term;
  mult_term_t                w_next_term;
  logic signed [P_W-1:0]     w_pp;
  logic                      w_bypass;

  // Highest nonzero digit is p; next nonzero below it is q (if any).
  function automatic mult_term_t pick_pair(input naf_digit_t [B_W-1:0] d);
    mult_term_t t;
    logic       have_p;
    logic       have_q;
    t      = '0;
    have_p = 1'b0;
    have_q = 1'b0;
    for (int k = B_W - 1; k >= 0; k--) begin
      if (d[k] != DIGIT_ZERO) begin
        if (!have_p) begin
          have_p     = 1'b1;
          t.i        = k[N-1:0];
          t.neg      = d[k][1];
          t.one_term = 1'b1;
        end else if (!have_q) begin
          have_q     = 1'b1;
          t.j        = k[N-1:0];
          t.one_term = 1'b0;
          t.b_sign   = d[k][1] ^ t.neg;
        end
      end
    end
    return t;
  endfunction

  naf_encoder u_naf_encoder (
    .i_b      (r_b),
    .o_digits (w_enc_digits)
  );

  assign w_first_term = pick_pair(w_enc_digits);
  assign w_next_term  = pick_pair(r_digits);
  assign w_pp         = {{(P_W-2*A_N){1'b0}}, m_c};

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign w_bypass = (w_enc_digits == '0) || (r_a == '0);
`else
  assign w_bypass = (w_enc_digits == '0);
`endif

  // Digits left once the pair now in flight has been consumed.
  always_comb begin
    w_rem_digits           = r_digits;
    w_rem_digits[r_term.i] = DIGIT_ZERO;
    if (!r_term.one_term) begin
      w_rem_digits[r_term.j] = DIGIT_ZERO;
    end
  end

  // Sequencer FSM, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_digits  <= '0;
      r_term    <= '0;
      r_acc     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_m_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_vld) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_acc    <= '0;
            r_in_rdy <= 1'b0;
            r_state  <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          r_digits <= w_enc_digits;
          r_term   <= w_first_term;
          if (w_bypass) begin
            r_out_vld <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_m_vld <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_result_vld) begin
            r_acc    <= r_term.neg ? (r_acc - w_pp) : (r_acc + w_pp);
            r_digits <= w_rem_digits;
            r_m_vld  <= 1'b0;
            if (w_rem_digits == '0) begin
              r_out_vld <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_term  <= w_next_term;
          r_m_vld <= 1'b1;
          r_state <= ST_ISSUE;
        end
        ST_DONE: begin
          if (out_rdy) begin
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_rdy     = r_in_rdy;
  assign out_vld    = r_out_vld;
  assign out_p      = r_acc;
  assign m_a        = r_a;
  assign m_b_i      = r_term.i;
  assign m_b_j      = r_term.j;
  assign m_one_term = r_term.one_term;
  assign m_b_sign   = r_term.b_sign;
  assign m_vld      = r_m_vld;

endmodule

// File: tb/tb_mult_term_sequencer.sv
// Self-checking bench for mult_term_sequencer: directed vector table,
// reset-abort sequence and randomized operands against a NAF/product model.
module tb_mult_term_sequencer;
  import mult_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_vld = 1'b0;
  logic                  in_rdy;
  logic [A_N-1:0]        in_a = '0;
  logic [B_W-1:0]        in_b = '0;
  logic                  out_vld;
  logic                  out_rdy = 1'b0;
  logic signed [P_W-1:0] out_p;
  logic [A_N-1:0]        m_a;
  logic [N-1:0]          m_b_i;
  logic [N-1:0]          m_b_j;
  logic                  m_one_term;
  logic                  m_b_sign;
  logic                  m_vld;
  logic [2*A_N-1:0]      m_c = '0;
  logic                  m_result_vld = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_term_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_p        (out_p),
    .m_a          (m_a),
    .m_b_i        (m_b_i),
    .m_b_j        (m_b_j),
    .m_one_term   (m_one_term),
    .m_b_sign     (m_b_sign),
    .m_vld        (m_vld),
    .m_c          (m_c),
    .m_result_vld (m_result_vld)
  );

  typedef struct {
    int i;
    int j;
    bit one;
    bit bsign;
  } req_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    int          hold;
    bit          spur;
    longint      exp_p;
    int          exp_n;
    int          exp_i;
    int          exp_j;
    bit          exp_one;
    bit          exp_bsign;
  } vec_t;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  localparam int ZERO_A_REQS = 0;
`else
  localparam int ZERO_A_REQS = 1;
`endif

  req_t exp_q[$];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: NAF by integer division, then pair digits from the top.
  function automatic void build_model(input logic [15:0] b);
    longint x;
    int     d[16];
    int     nz[$];
    int     p;
    int     q;
    req_t   r;
    exp_q.delete();
    x = longint'($signed(b));
    for (int k = 0; k < 16; k++) begin
      d[k] = 0;
      if (x % 2 != 0) begin
        d[k] = 2 - int'(((x % 4) + 4) % 4);
        x = (x - longint'(d[k])) / 2;
      end else begin
        x = x / 2;
      end
    end
    for (int k = 15; k >= 0; k--) begin
      if (d[k] != 0) nz.push_back(k);
    end
    while (nz.size() > 0) begin
      p = nz.pop_front();
      r.i = p; r.j = 0; r.one = 1'b1; r.bsign = 1'b0;
      if (nz.size() > 0) begin
        q = nz.pop_front();
        r.j = q; r.one = 1'b0; r.bsign = (d[p] != d[q]);
      end
      exp_q.push_back(r);
    end
  endfunction

  // One operation: accept, act as the multiplier with fixed latency, check
  // requests/timing/product, optionally hold out_rdy low, then release.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                        input int hold, input bit spur,
                        output longint got_p, output int got_n, output req_t first);
    int     guard;
    int     cyc;
    int     cnt;
    int     last_res;
    bit     busy;
    bit     done;
    req_t   cur;
    longint mc;
    longint pi;
    longint pj;
    longint exp_p;
    logic signed [P_W-1:0] p_hold;

    build_model(b);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    if (a == 16'd0) exp_q.delete();
`endif
    exp_p = longint'(a) * longint'($signed(b));
    got_n = 0;
    got_p = 0;
    first = '{default: 0};
    cur   = first;

    guard = 0;
    while (!in_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_rdy_before_accept", longint'(in_rdy), 1);
    in_vld = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_vld = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    cyc = 1; busy = 0; done = 0; cnt = 0; last_res = 0; mc = 0;
    check("in_rdy_after_accept", longint'(in_rdy), 0);

    while (!done && cyc < 400) begin
      m_result_vld = 1'b0;
      in_vld = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_vld) begin
        check("out_vld_cycle", longint'(cyc), longint'((got_n == 0) ? 2 : last_res + 1));
        check("m_vld_in_done", longint'(m_vld), 0);
        done = 1;
        in_vld = 1'b0;
      end else if (m_vld) begin
        if (!busy) begin
          busy = 1; cnt = 0; got_n++;
          cur.i = int'(m_b_i); cur.j = int'(m_b_j);
          cur.one = m_one_term; cur.bsign = m_b_sign;
          if (got_n == 1) begin
            first = cur;
            check("first_req_cycle", longint'(cyc), 2);
          end else begin
            check("gap_len", longint'(cyc - last_res), 2);
          end
          check("m_a", longint'(m_a), longint'(a));
          if (got_n <= exp_q.size()) begin
            check("req_i", longint'(cur.i), longint'(exp_q[got_n-1].i));
            check("req_j", longint'(cur.j), longint'(exp_q[got_n-1].j));
            check("req_one_term", longint'(cur.one), longint'(exp_q[got_n-1].one));
            check("req_b_sign", longint'(cur.bsign), longint'(exp_q[got_n-1].bsign));
          end else begin
            check("extra_req", longint'(got_n), longint'(exp_q.size()));
          end
          pi = longint'(1) << cur.i;
          pj = longint'(1) << cur.j;
          mc = longint'(a) * (cur.one ? pi : (cur.bsign ? pi - pj : pi + pj));
        end else begin
          check("req_stable",
                longint'(int'(m_b_i) == cur.i && int'(m_b_j) == cur.j &&
                         m_one_term == cur.one && m_b_sign == cur.bsign && m_a == a), 1);
        end
        cnt++;
        if (cnt >= lat) begin
          m_result_vld = 1'b1;
          m_c = mc[31:0];
          busy = 0;
          last_res = cyc;
        end else begin
          m_c = $urandom;
        end
      end else begin
        if (busy) check("m_vld_held", longint'(m_vld), 1);
        busy = 0;
        if (spur) begin
          m_result_vld = 1'($urandom_range(0, 1));
          m_c = $urandom;
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_result_vld = 1'b0;
    in_vld = 1'b0;

    check("done_reached", longint'(done), 1);
    check("req_count", longint'(got_n), longint'(exp_q.size()));
    p_hold = out_p;
    got_p  = longint'(out_p);
    check("product_model", got_p, exp_p);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_vld", longint'(out_vld), 1);
      check("hold_out_p", longint'(out_p), longint'(p_hold));
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("idle_in_rdy", longint'(in_rdy), 1);
    check("idle_out_vld", longint'(out_vld), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[$];
    longint p;
    int     n;
    req_t   f;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs.push_back('{16'd3,     16'd5,      1, 0, 0, 64'sd15,          1, 2, 0, 1'b0, 1'b0});
    vecs.push_back('{16'd3,     16'd7,      2, 0, 1, 64'sd21,          1, 3, 0, 1'b0, 1'b1});
    vecs.push_back('{16'd3,     16'hFFFD,   2, 0, 0, -64'sd9,          1, 2, 0, 1'b0, 1'b1});
    vecs.push_back('{16'd1000,  16'h5555,   3, 0, 1, 64'sd21845000,    4, 14, 12, 1'b0, 1'b0});
    vecs.push_back('{16'd65535, 16'h8000,   2, 5, 0, -64'sd2147450880, 1, 15, 0, 1'b1, 1'b0});
    vecs.push_back('{16'd5,     16'd0,      1, 2, 0, 64'sd0,           0, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF,  16'h7FFF,   4, 0, 0, 64'sd2147385345,  1, 15, 0, 1'b0, 1'b1});
    vecs.push_back('{16'd9,     16'hFFFF,   1, 0, 0, -64'sd9,          1, 0, 0, 1'b1, 1'b0});
    vecs.push_back('{16'd0,     16'd7,      2, 0, 0, 64'sd0, ZERO_A_REQS, 3, 0, 1'b0, 1'b1});
    vecs.push_back('{16'd12345, 16'd1,      1, 0, 0, 64'sd12345,       1, 0, 0, 1'b1, 1'b0});
    vecs.push_back('{16'd7,     16'd43,     2, 1, 1, 64'sd301,         2, 6, 4, 1'b0, 1'b1});

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_rdy", longint'(in_rdy), 1);
    check("rst_out_vld", longint'(out_vld), 0);
    check("rst_out_p", longint'(out_p), 0);
    check("rst_m_vld", longint'(m_vld), 0);
    check("rst_m_fields", longint'({m_a, m_b_i, m_b_j, m_one_term, m_b_sign}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].lat, vecs[k].hold, vecs[k].spur, p, n, f);
      check($sformatf("vec%0d_p", k), p, vecs[k].exp_p);
      check($sformatf("vec%0d_n", k), longint'(n), longint'(vecs[k].exp_n));
      if (vecs[k].exp_n > 0 && n > 0) begin
        check($sformatf("vec%0d_i", k), longint'(f.i), longint'(vecs[k].exp_i));
        check($sformatf("vec%0d_j", k), longint'(f.j), longint'(vecs[k].exp_j));
        check($sformatf("vec%0d_one", k), longint'(f.one), longint'(vecs[k].exp_one));
        check($sformatf("vec%0d_bsign", k), longint'(f.bsign), longint'(vecs[k].exp_bsign));
      end
    end

    // Reset while ISSUE waits on a slow multiplier; the late result must be ignored.
    in_vld = 1'b1; in_a = 16'd7; in_b = 16'd5;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    check("abort_m_vld_issue", longint'(m_vld), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_rdy", longint'(in_rdy), 1);
    check("abort_out_vld", longint'(out_vld), 0);
    check("abort_out_p", longint'(out_p), 0);
    check("abort_m_vld", longint'(m_vld), 0);
    check("abort_m_fields", longint'({m_a, m_b_i, m_b_j, m_one_term, m_b_sign}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_result_vld = 1'b1;
    m_c = 32'd35;
    @(negedge clk);
    m_result_vld = 1'b0;
    check("late_result_out_vld", longint'(out_vld), 0);
    check("late_result_in_rdy", longint'(in_rdy), 1);
    check("late_result_m_vld", longint'(m_vld), 0);
    run_op(16'd2, 16'd1, 2, 0, 0, p, n, f);
    check("after_reset_p", p, 2);
    check("after_reset_n", longint'(n), 1);

    // Randomized operands against the model inside run_op.
    for (int r = 0; r < 40; r++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1:       rb = 16'h8000;
        2:       rb = 16'h7FFF;
        default: rb = 16'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), p, n, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
